// File: rtl/ristretto_data_mem_resp_pkg.sv
// Shared channel-state type and default sizing for the ristretto data-memory responder.
package ristretto_mem_pkg;

    localparam int DefMemWords   = 1024;
    localparam int DefWaitStates = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } chan_state_e;

endpackage

// File: rtl/ristretto_data_mem_resp_if.sv
// Read and write request/response channels between the core and the data memory.
interface ristretto_data_mem_resp_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                     rdata_req;
    logic [AddrWidth-1:0]     rdata_addr;
    logic [DataWidth/8-1:0]   rdata_strb;
    logic                     rdata_ready;
    logic                     rdata_valid;
    logic [DataWidth-1:0]     rdata_data;

    logic                     wdata_req;
    logic [AddrWidth-1:0]     wdata_addr;
    logic [DataWidth-1:0]     wdata_data;
    logic [DataWidth/8-1:0]   wdata_strb;
    logic                     wdata_ready;
    logic                     wdata_valid;

    modport master (
        output rdata_req, rdata_addr, rdata_strb,
        input  rdata_ready, rdata_valid, rdata_data,
        output wdata_req, wdata_addr, wdata_data, wdata_strb,
        input  wdata_ready, wdata_valid
    );

    modport slave (
        input  rdata_req, rdata_addr, rdata_strb,
        output rdata_ready, rdata_valid, rdata_data,
        input  wdata_req, wdata_addr, wdata_data, wdata_strb,
        output wdata_ready, wdata_valid
    );

endinterface

// File: rtl/ristretto_data_mem_resp_sram.sv
// Single-port word storage with per-byte write enables and a registered read.
module ristretto_sram_1p #(
    parameter  int DataWidth = 32,
    parameter  int MemWords  = 1024,
    localparam int IdxW      = $clog2(MemWords),
    localparam int NumBytes  = DataWidth / 8
) (
    input  logic                 clk,
    input  logic                 req,
    input  logic                 we,
    input  logic [NumBytes-1:0]  be,
    input  logic [IdxW-1:0]      addr,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [MemWords];

    // Read register only moves on a read access, so it holds across writes.
    always_ff @(posedge clk) begin
        if (req && we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end else if (req) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ristretto_data_mem_resp.sv
// Data-memory responder: independent read and write channel FSMs sharing one single-port SRAM.
//   state | meaning
//   IDLE  | ready for a request (read also yields to a simultaneous write)
//   WAIT  | request captured, counting down wait states
//   RESP  | one-cycle valid pulse
module ristretto_data_mem_resp
    import ristretto_mem_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int MemWords   = DefMemWords,
    parameter int WaitStates = DefWaitStates
) (
    input logic                     clk_i,
    input logic                     rst_i,
    ristretto_data_mem_resp_if.slave bus
);

    localparam int         IdxW     = $clog2(MemWords);
    localparam logic [2:0] WaitLoad = (WaitStates == 0) ? 3'd0 : 3'(WaitStates - 1);

    chan_state_e          rd_state;
    chan_state_e          wr_state;
    logic [2:0]           rd_cnt;
    logic [2:0]           wr_cnt;
    logic                 rd_valid;
    logic                 wr_valid;
    logic                 rd_ready;
    logic                 wr_ready;
    logic                 rd_accept;
    logic                 wr_accept;
    logic [IdxW-1:0]      rd_idx;
    logic [IdxW-1:0]      wr_idx;
    logic [DataWidth-1:0] sram_q;
    logic [DataWidth-1:0] rd_hold;
    logic                 unused_bits;

    assign rd_idx = bus.rdata_addr[IdxW+1:2];
    assign wr_idx = bus.wdata_addr[IdxW+1:2];
    assign unused_bits = ^{bus.rdata_addr, bus.wdata_addr, bus.rdata_strb};

    // The write wins the single port when both channels ask from IDLE together.
    assign wr_ready  = !rst_i && (wr_state == IDLE);
    assign rd_ready  = !rst_i && (rd_state == IDLE) && !(bus.wdata_req && (wr_state == IDLE));
    assign wr_accept = bus.wdata_req && wr_ready;
    assign rd_accept = bus.rdata_req && rd_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state <= IDLE;
            wr_cnt   <= 3'd0;
            wr_valid <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            unique case (wr_state)
                IDLE: if (wr_accept) begin
                    if (WaitStates == 0) begin
                        wr_state <= RESP;
                        wr_valid <= 1'b1;
                    end else begin
                        wr_state <= WAIT;
                        wr_cnt   <= WaitLoad;
                    end
                end
                WAIT: if (wr_cnt == 3'd0) begin
                    wr_state <= RESP;
                    wr_valid <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt - 3'd1;
                end
                RESP:    wr_state <= IDLE;
                default: wr_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state <= IDLE;
            rd_cnt   <= 3'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            unique case (rd_state)
                IDLE: if (rd_accept) begin
                    if (WaitStates == 0) begin
                        rd_state <= RESP;
                        rd_valid <= 1'b1;
                    end else begin
                        rd_state <= WAIT;
                        rd_cnt   <= WaitLoad;
                    end
                end
                WAIT: if (rd_cnt == 3'd0) begin
                    rd_state <= RESP;
                    rd_valid <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt - 3'd1;
                end
                RESP:    rd_state <= IDLE;
                default: rd_state <= IDLE;
            endcase
        end
    end

    // Response data shows in RESP and is then latched so a later read's SRAM access is hidden.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_hold <= '0;
        end else if (rd_state == RESP) begin
            rd_hold <= sram_q;
        end
    end

    ristretto_sram_1p #(
        .DataWidth (DataWidth),
        .MemWords  (MemWords)
    ) u_sram (
        .clk   (clk_i),
        .req   (wr_accept || rd_accept),
        .we    (wr_accept),
        .be    (bus.wdata_strb),
        .addr  (wr_accept ? wr_idx : rd_idx),
        .wdata (bus.wdata_data),
        .rdata (sram_q)
    );

    assign bus.wdata_ready = wr_ready;
    assign bus.wdata_valid = wr_valid;
    assign bus.rdata_ready = rd_ready;
    assign bus.rdata_valid = rd_valid;
    assign bus.rdata_data  = (rd_state == RESP) ? sram_q : rd_hold;

endmodule

// File: tb/tb_ristretto_data_mem_resp.sv
// Directed bench for ristretto_data_mem_resp: one instance with one wait state, one with none.
module tb_ristretto_data_mem_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [1024];
    logic [31:0] last_rd = 32'd0;

    always #5 clk = ~clk;

    ristretto_data_mem_resp_if #(.DataWidth(32), .AddrWidth(32)) m0 ();
    ristretto_data_mem_resp_if #(.DataWidth(32), .AddrWidth(32)) m1 ();

    ristretto_data_mem_resp #(
        .DataWidth(32), .AddrWidth(32), .MemWords(1024), .WaitStates(1)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (m0)
    );

    ristretto_data_mem_resp #(
        .DataWidth(32), .AddrWidth(32), .MemWords(1024), .WaitStates(0)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (m1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        logic [31:0] e;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data", obs, e);
            last_rd = e;
        end
    endtask

    task automatic m0_accept_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        m0.wdata_req = 1'b1; m0.wdata_addr = a; m0.wdata_data = d; m0.wdata_strb = s;
        #1;
        n = 0;
        while (m0.wdata_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        chk("wr_ready", 32'(m0.wdata_ready), 32'd1);
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) if (s[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
        m0.wdata_req = 1'b0; m0.wdata_data = ~d; m0.wdata_strb = ~s;
    endtask

    task automatic m0_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int lat;
        m0_accept_write(a, d, s);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (m0.wdata_valid === 1'b1) lat = i;
        end
        chk("wr_latency", 32'(lat), 32'd2);
        @(negedge clk);
        chk("wr_valid_pulse", 32'(m0.wdata_valid), 32'd0);
    endtask

    task automatic m0_accept_read(input logic [31:0] a);
        int n;
        @(negedge clk);
        m0.rdata_req = 1'b1; m0.rdata_addr = a; m0.rdata_strb = 4'hF;
        #1;
        n = 0;
        while (m0.rdata_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        chk("rd_ready", 32'(m0.rdata_ready), 32'd1);
        @(posedge clk); #1;
        m0.rdata_req = 1'b0; m0.rdata_addr = ~a;
    endtask

    task automatic m0_read(input logic [31:0] a);
        int lat;
        m0_accept_read(a);
        exp_q.push_back(model[a[11:2]]);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (m0.rdata_valid === 1'b1) begin
                lat = i;
                sb_pop(m0.rdata_data);
            end else begin
                chk("rd_hold", m0.rdata_data, last_rd);
            end
        end
        chk("rd_latency", 32'(lat), 32'd2);
        @(negedge clk);
        chk("rd_valid_pulse", 32'(m0.rdata_valid), 32'd0);
        chk("rd_hold_after", m0.rdata_data, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int wl, rl, hits, acc, last_acc, nvalid;
        m0.rdata_req = 1'b0; m0.rdata_addr = '0; m0.rdata_strb = '0;
        m0.wdata_req = 1'b0; m0.wdata_addr = '0; m0.wdata_data = '0; m0.wdata_strb = '0;
        m1.rdata_req = 1'b0; m1.rdata_addr = '0; m1.rdata_strb = '0;
        m1.wdata_req = 1'b0; m1.wdata_addr = '0; m1.wdata_data = '0; m1.wdata_strb = '0;

        // reset state
        repeat (3) @(negedge clk);
        m0.rdata_req = 1'b1; m0.wdata_req = 1'b1;
        #1;
        chk("rst_rd_ready", 32'(m0.rdata_ready), 32'd0);
        chk("rst_wr_ready", 32'(m0.wdata_ready), 32'd0);
        chk("rst_rd_valid", 32'(m0.rdata_valid), 32'd0);
        chk("rst_wr_valid", 32'(m0.wdata_valid), 32'd0);
        chk("rst_rd_data", m0.rdata_data, 32'd0);
        m0.rdata_req = 1'b0; m0.wdata_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rd_ready", 32'(m0.rdata_ready), 32'd1);
        chk("post_rst_wr_ready", 32'(m0.wdata_ready), 32'd1);
        chk("post_rst_ws0_ready", 32'(m1.rdata_ready), 32'd1);

        // full write then read back
        m0_write(32'h10, 32'hDEADBEEF, 4'hF);
        m0_read(32'h10);
        chk("s1_data", m0.rdata_data, 32'hDEADBEEF);

        // single-byte strobe
        m0_write(32'h10, 32'h000000AA, 4'h1);
        m0_read(32'h10);
        chk("s2_data", m0.rdata_data, 32'hDEADBEAA);

        // same-cycle read and write to one word
        @(negedge clk);
        m0.wdata_req = 1'b1; m0.wdata_addr = 32'h20; m0.wdata_data = 32'h12345678; m0.wdata_strb = 4'hF;
        m0.rdata_req = 1'b1; m0.rdata_addr = 32'h20; m0.rdata_strb = 4'hF;
        #1;
        chk("conflict_rd_ready", 32'(m0.rdata_ready), 32'd0);
        chk("conflict_wr_ready", 32'(m0.wdata_ready), 32'd1);
        @(posedge clk); #1;
        m0.wdata_req = 1'b0;
        model[8] = 32'h12345678;
        @(negedge clk);
        chk("conflict_rd_next_ready", 32'(m0.rdata_ready), 32'd1);
        @(posedge clk); #1;
        m0.rdata_req = 1'b0;
        exp_q.push_back(model[8]);
        wl = 0; rl = 0;
        for (int i = 1; i <= 8 && (wl == 0 || rl == 0); i++) begin
            @(negedge clk);
            if (m0.wdata_valid === 1'b1 && wl == 0) wl = i;
            if (m0.rdata_valid === 1'b1 && rl == 0) begin
                rl = i;
                sb_pop(m0.rdata_data);
            end
        end
        chk("conflict_wr_latency", 32'(wl), 32'd1);
        chk("conflict_rd_latency", 32'(rl), 32'd2);
        chk("s3_data", m0.rdata_data, 32'h12345678);

        // held data survives the next read's wait cycle
        m0_read(32'h10);
        m0_read(32'h20);

        // aliasing of upper address bits
        m0_write(32'h1000, 32'h00000005, 4'hF);
        m0_read(32'h0);
        chk("s4_alias", m0.rdata_data, 32'h00000005);

        // zero strobe completes without changing storage
        m0_write(32'h10, 32'hFFFFFFFF, 4'h0);
        m0_read(32'h10);
        chk("s5_strb0", m0.rdata_data, 32'hDEADBEAA);

        // reset aborts an in-flight write but keeps it committed
        m0_accept_write(32'h30, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_wr_valid", 32'(m0.wdata_valid), 32'd0);
        chk("abort_rd_data", m0.rdata_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; last_rd = 32'd0;
        #1;
        chk("abort_wr_ready", 32'(m0.wdata_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (m0.wdata_valid === 1'b1) hits++; end
        chk("abort_wr_no_valid", 32'(hits), 32'd0);

        // reset during a read's WAIT
        m0_read(32'h20);
        m0_accept_read(32'h10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rd_data_rst", m0.rdata_data, 32'd0);
        chk("abort_rd_ready_rst", 32'(m0.rdata_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; last_rd = 32'd0;
        #1;
        chk("abort_rd_ready", 32'(m0.rdata_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (m0.rdata_valid === 1'b1) hits++; end
        chk("abort_rd_no_valid", 32'(hits), 32'd0);
        m0_read(32'h30);
        chk("s6_committed", m0.rdata_data, 32'hCAFEF00D);
        m0_read(32'h20);

        // zero wait states: writes then back-to-back reads
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            m1.wdata_req = 1'b1; m1.wdata_addr = 32'h40 + 32'(4 * k);
            m1.wdata_data = (k == 0) ? 32'h11111111 : 32'h22222222; m1.wdata_strb = 4'hF;
            #1;
            chk("ws0_wr_ready", 32'(m1.wdata_ready), 32'd1);
            @(posedge clk); #1;
            m1.wdata_req = 1'b0;
            @(negedge clk);
            chk("ws0_wr_valid", 32'(m1.wdata_valid), 32'd1);
        end
        @(negedge clk);
        m1.rdata_req = 1'b1; m1.rdata_addr = 32'h40; m1.rdata_strb = 4'hF;
        acc = 0; last_acc = -10; nvalid = 0;
        for (int cyc = 0; cyc < 16 && nvalid < 3; cyc++) begin
            #1;
            if (m1.rdata_valid === 1'b1) begin
                nvalid++;
                chk("ws0_rd_latency", 32'(cyc - last_acc), 32'd1);
                sb_pop(m1.rdata_data);
            end
            if (m1.rdata_req === 1'b1 && m1.rdata_ready === 1'b1) begin
                if (acc > 0) chk("ws0_acc_gap", 32'(cyc - last_acc), 32'd2);
                exp_q.push_back(m1.rdata_addr[2] ? 32'h22222222 : 32'h11111111);
                last_acc = cyc; acc++;
                @(posedge clk); #1;
                m1.rdata_addr = m1.rdata_addr ^ 32'h4;
                if (acc == 3) m1.rdata_req = 1'b0;
            end
            @(negedge clk);
        end
        chk("ws0_valid_count", 32'(nvalid), 32'd3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
